// File: rtl/uart9_rx_ctrl.sv
// 8051-style serial receiver for UART modes 1/2/3: majority-voted sampling,
// false-start rejection, SM2 address filtering and RI/FE/OE flag handshake.
module uart9_rx_ctrl #(
  parameter int CLK_PER_BIT = 100,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 ren,
  input  logic                 mode9,
  input  logic                 sm2,
  input  logic                 ri_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rb8,
  output logic                 ri,
  output logic                 fe,
  output logic                 oe,
  output logic                 busy
);

  localparam int H  = CLK_PER_BIT / 2;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, BIT9, STOP} state_t;

  state_t               state_q, nxt;
  logic                 rx_m, rxs, rxs_d;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp0, smp1, bit9_q, m9_q, sm2_q;
  logic                 start_edge, dec, wrap, maj, frame_bit;
  logic                 accept, fe_set, oe_set;

  // rx_m/rxs form the synchroniser; rxs_d only exists for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_m  <= rxd;
      rxs   <= rx_m;
      rxs_d <= rxs;
    end
  end

  assign start_edge = rxs_d & ~rxs;
  assign dec        = (clk_cnt == CNT_DEC);
  assign wrap       = (clk_cnt == CNT_LAST);
  assign maj        = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
  // Filter bit and rb8 share one source: 9th bit in 9-bit mode, else stop bit
  assign frame_bit  = m9_q ? bit9_q : maj;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= nxt;
  end

  always_comb begin
    nxt    = state_q;
    accept = 1'b0;
    fe_set = 1'b0;
    oe_set = 1'b0;
    case (state_q)
      IDLE:  if (ren && start_edge) nxt = START;
      START: begin
        if (!ren)            nxt = IDLE;
        else if (dec && maj) nxt = IDLE;
        else if (wrap)       nxt = DATA;
      end
      DATA: begin
        if (!ren)                            nxt = IDLE;
        else if (wrap && bit_idx == BIT_LAST) nxt = m9_q ? BIT9 : STOP;
      end
      BIT9: begin
        if (!ren)      nxt = IDLE;
        else if (wrap) nxt = STOP;
      end
      STOP: begin
        if (!ren) nxt = IDLE;
        else if (dec) begin
          // Resolve early so a new start edge in the back half of stop is seen
          nxt = IDLE;
          if (!maj)                     fe_set = 1'b1;
          else if (ri && !ri_clr)       oe_set = 1'b1;
          else if (!(sm2_q && !frame_bit)) accept = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      smp0    <= 1'b0;
      smp1    <= 1'b0;
      bit9_q  <= 1'b0;
      m9_q    <= 1'b0;
      sm2_q   <= 1'b0;
    end else begin
      if (state_q == IDLE || wrap) clk_cnt <= '0;
      else                         clk_cnt <= clk_cnt + 1'b1;

      if (state_q != DATA)                  bit_idx <= '0;
      else if (wrap && bit_idx != BIT_LAST) bit_idx <= bit_idx + 1'b1;

      if (clk_cnt == CNT_S0) smp0 <= rxs;
      if (clk_cnt == CNT_S1) smp1 <= rxs;

      if (state_q == DATA && dec) shreg  <= {maj, shreg[DATA_BITS-1:1]};
      if (state_q == BIT9 && dec) bit9_q <= maj;

      // Frame format is frozen at the start edge
      if (state_q == IDLE && nxt == START) begin
        m9_q  <= mode9;
        sm2_q <= sm2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rb8      <= 1'b0;
      ri       <= 1'b0;
      fe       <= 1'b0;
      oe       <= 1'b0;
    end else begin
      if (accept) begin
        data_out <= shreg;
        rb8      <= frame_bit;
      end
      ri <= accept | (ri & ~ri_clr);
      fe <= fe_set | (fe & ~ri_clr);
      oe <= oe_set | (oe & ~ri_clr);
    end
  end

endmodule

// File: tb/tb_uart9_rx_ctrl.sv
// Scoreboard bench for uart9_rx_ctrl: stimulus predicts each frame outcome,
// a negedge monitor compares it when busy falls.
module tb_uart9_rx_ctrl;
  localparam int CPB = 100;
  localparam int DB  = 8;
  localparam int H   = CPB / 2;

  logic          clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, ren = 1'b0;
  logic          mode9 = 1'b0, sm2 = 1'b0, ri_clr = 1'b0;
  logic [DB-1:0] data_out;
  logic          rb8, ri, fe, oe, busy;

  uart9_rx_ctrl #(.CLK_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .ren(ren), .mode9(mode9), .sm2(sm2),
    .ri_clr(ri_clr), .data_out(data_out), .rb8(rb8), .ri(ri), .fe(fe),
    .oe(oe), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct {
    int        fall;
    logic [7:0] data;
    logic      rb8, ri, fe, oe;
    string     tag;
  } exp_t;
  exp_t q[$];

  // reference model of the SBUF/SCON-visible state
  logic [7:0] m_data = '0;
  logic m_rb8 = 0, m_ri = 0, m_fe = 0, m_oe = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input int fall, input string tag);
    exp_t e;
    e.fall = fall; e.data = m_data; e.rb8 = m_rb8;
    e.ri = m_ri; e.fe = m_fe; e.oe = m_oe; e.tag = tag;
    q.push_back(e);
  endtask

  // Frame outcome from the receiver rules; clr = ri_clr lands on the decision
  task automatic predict(input logic [7:0] d, input logic m9, input logic s2,
                         input logic b9, input logic stp, input bit clr);
    logic fbit;
    fbit = m9 ? b9 : stp;
    if (!stp) begin
      m_fe = 1;
      if (clr) begin m_ri = 0; m_oe = 0; end
    end else if (m_ri && !clr) begin
      m_oe = 1;
    end else if (s2 && !fbit) begin
      if (clr) begin m_ri = 0; m_fe = 0; m_oe = 0; end
    end else begin
      m_data = d; m_rb8 = fbit; m_ri = 1;
      if (clr) begin m_fe = 0; m_oe = 0; end
    end
  endtask

  // clr_at: -1 none, -2 on the stop decision cycle, else frame-relative cycle
  // spike_at: frame-relative cycle where the line is inverted for one cycle
  task automatic send_frame(input logic [7:0] d, input logic m9, input logic s2,
                            input logic b9, input logic stp, input int clr_at,
                            input int spike_at, input bit scramble, input string tag);
    int S, n, c0, dc, ca;
    logic [10:0] bits;
    S  = DB + 1 + int'(m9);
    n  = (S + 1) * CPB;
    dc = S * CPB + H + 4;
    ca = (clr_at == -2) ? dc : clr_at;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = d[i];
    if (m9) bits[DB+1] = b9;
    bits[S] = stp;
    c0 = cyc;
    if (ca >= 0 && ca != dc) begin m_ri = 0; m_fe = 0; m_oe = 0; end
    predict(d, m9, s2, b9, stp, ca == dc);
    push_exp(c0 + S * CPB + H + 5, tag);
    for (int t = 0; t < n; t++) begin
      if (t == 0) begin mode9 = m9; sm2 = s2; end
      if (scramble && t == CPB) begin mode9 = 1'($urandom); sm2 = 1'($urandom); end
      rxd    = bits[t / CPB] ^ logic'(t == spike_at);
      ri_clr = (t == ca);
      step();
    end
    ri_clr = 1'b0;
    rxd    = 1'b1;
  endtask

  task automatic pulse_clr(input string tag);
    ri_clr = 1'b1; step(); ri_clr = 1'b0;
    m_ri = 0; m_fe = 0; m_oe = 0;
    step();
    chk({tag, ".ri"}, 32'(ri), 32'(m_ri));
    chk({tag, ".fe"}, 32'(fe), 32'(m_fe));
    chk({tag, ".oe"}, 32'(oe), 32'(m_oe));
  endtask

  task automatic glitch(input int low_len, input string tag);
    int c0;
    c0 = cyc;
    push_exp(c0 + H + 5, tag);
    rxd = 1'b0;
    repeat (low_len) step();
    rxd = 1'b1;
    repeat (H + 20 - low_len) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), 0);
    chk({tag, ".rb8"}, 32'(rb8), 0);
    chk({tag, ".ri"}, 32'(ri), 0);
    chk({tag, ".fe"}, 32'(fe), 0);
    chk({tag, ".oe"}, 32'(oe), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  // Monitor: one scoreboard entry per frame end (busy falling)
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_q = 1'b0;
    end else begin
      if (busy_q && !busy) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_end: busy fell at cycle %0d, none expected", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.tag, ".cycle"}, 32'(cyc), 32'(e.fall));
          chk({e.tag, ".data_out"}, 32'(data_out), 32'(e.data));
          chk({e.tag, ".rb8"}, 32'(rb8), 32'(e.rb8));
          chk({e.tag, ".ri"}, 32'(ri), 32'(e.ri));
          chk({e.tag, ".fe"}, 32'(fe), 32'(e.fe));
          chk({e.tag, ".oe"}, 32'(oe), 32'(e.oe));
        end
      end
      busy_q = busy;
    end
  end

  initial begin
    int gap, spk, ca, slots;
    logic [7:0] d;
    logic m9, s2, b9, stp;

    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1; ren = 1'b1;
    repeat (5) step();

    send_frame(8'hA5, 1, 0, 1, 1, -1, -1, 0, "a5_9bit");
    // reset at E+300 of the next frame while ri/data_out are live
    mode9 = 1'b1; rxd = 1'b0;
    repeat (302) step();
    rst_n = 1'b0; #1;
    check_all_zero("reset_mid");
    m_data = '0; m_rb8 = 0; m_ri = 0; m_fe = 0; m_oe = 0;
    rxd = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    send_frame(8'hC3, 1, 0, 1, 1, -1, -1, 0, "after_reset");
    pulse_clr("clr1");

    send_frame(8'h3C, 1, 1, 0, 1, -1, -1, 0, "sm2_data");
    send_frame(8'h7E, 1, 1, 1, 1, -1, -1, 0, "sm2_addr");
    pulse_clr("clr2");

    glitch(30, "false_start");
    send_frame(8'h00, 1, 0, 0, 1, -1, 3 * CPB + H + 1, 0, "spike");
    pulse_clr("clr3");

    send_frame(8'h11, 0, 0, 0, 1, -1, -1, 0, "ovr_first");
    send_frame(8'h22, 0, 0, 0, 1, -1, -1, 0, "ovr_lost");
    send_frame(8'h22, 0, 0, 0, 1, -2, -1, 0, "ovr_clr_at_dec");
    pulse_clr("clr4");

    send_frame(8'h55, 0, 0, 0, 0, -1, -1, 0, "framing");
    pulse_clr("clr5");

    send_frame(8'h01, 0, 0, 0, 1, -1, -1, 0, "b2b_1");
    send_frame(8'h02, 0, 0, 0, 1, 2 * CPB, -1, 0, "b2b_2");
    pulse_clr("clr6");

    for (int i = 0; i < 25; i++) begin
      d   = 8'($urandom);
      m9  = 1'($urandom);
      s2  = 1'($urandom);
      b9  = 1'($urandom);
      stp = ($urandom_range(0, 5) != 0);
      slots = DB + 2 + int'(m9);
      ca  = ($urandom_range(0, 3) == 0) ? -2 : -1;
      spk = ($urandom_range(0, 1) == 0) ? -1
            : int'($urandom_range(0, slots - 1)) * CPB + H + 1;
      if ($urandom_range(0, 1) == 0) pulse_clr("rnd_clr");
      if ($urandom_range(0, 7) == 0) glitch(int'($urandom_range(1, H - 5)), "rnd_glitch");
      send_frame(d, m9, s2, b9, stp, ca, spk, 1, $sformatf("rnd%0d", i));
      gap = int'($urandom_range(0, 20));
      repeat (gap) step();
    end

    for (int w = 0; w < 2000 && q.size() != 0; w++) step();
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d frame ends still pending, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart9_rx_ctrl.md
# uart9_rx_ctrl

Parametrised 8051-style serial receiver covering UART modes 1, 2 and 3 with one RTL block. Frame length is runtime-selectable as 8-bit (mode 1) or 9-bit (modes 2/3). Adds the following:
- 3-sample majority voting
- false-start rejection
- SM2 multiprocessor address filtering
- an RI handshake with overrun and framing-error flags

It sits between the pad-side `rxd` line and the SFR/SBUF logic of the serial port.

## Interface
- `CLK_PER_BIT`, 100, clk cycles per bit; legal ≥ 8. `H = CLK_PER_BIT/2` (integer division).
- `DATA_BITS`, 8, data bits per frame, LSB first; legal 5..8.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input, asynchronous to `clk`, idle high.
- `ren` in 1: receive enable (SCON.REN).
- `mode9` in 1: 1 = 9-bit frame (modes 2/3), 0 = 8-bit frame (mode 1).
- `sm2` in 1: multiprocessor filter enable (SCON.SM2).
- `ri_clr` in 1: one-cycle pulse that clears `ri`, `fe` and `oe`.
- `data_out` out `DATA_BITS`: last accepted data (SBUF).
- `rb8` out 1: 9th bit (`mode9`=1) or stop bit (`mode9`=0) of the last accepted frame.
- `ri` out 1: receive-complete flag, sticky until `ri_clr`.
- `fe` out 1: framing error, sticky.
- `oe` out 1: overrun, sticky.
- `busy` out 1: high while not IDLE.

## Operation
**Reset:** all outputs are 0, the state is IDLE, and both synchroniser flops are 1.

**Input path:** `rxd` goes through a 2-flop synchroniser to give `rxs`. `rxs_d` is `rxs` delayed by one cycle. A start edge is `rxs_d`=1 && `rxs`=0.

**States:** IDLE, START, DATA, BIT9, STOP.
- IDLE → START on a start edge while `ren`=1. On that transition, `clk_cnt` is set to 0 and `mode9`/`sm2` are latched for the whole frame.
- Every state counts `clk_cnt` from 0 to `CLK_PER_BIT-1` and then wraps; each wrap begins a new bit slot.
- Samples are taken at `clk_cnt` = H-1, H and H+1. At H+1 the bit value is the majority of those three samples.
- START: if the majority is 1, it is a false start; return to IDLE with no flag change. If the majority is 0, go to DATA at the slot wrap.
- DATA: shift the majority value into the shift register, LSB first. After `DATA_BITS` samples, go to BIT9 if `mode9`=1, otherwise go to STOP.
- BIT9: capture the 9th bit, then go to STOP.
- STOP: at the H+1 decision, resolve the frame (see below) and go to IDLE in the same cycle. This lets the next start edge be caught during the second half of the stop bit.

**Frame resolution.** `ri_eff` = `ri` && !`ri_clr`.
- Stop bit = 0: set `fe`. The frame is not accepted and `data_out`/`rb8`/`ri` are unchanged.
- Stop bit = 1 and `ri_eff`=1: set `oe`. The frame is discarded and `data_out`/`rb8` are unchanged.
- Stop bit = 1, `ri_eff`=0, and `sm2`=1 with the filter bit = 0: silently discard, with no flags. The filter bit is the 9th bit when `mode9`=1, or the stop bit when `mode9`=0.
- Otherwise accept: `data_out` ← shift register, `rb8` ← 9th bit or stop bit, `ri` ← 1.

**`ri_clr` behaviour:**
- When it coincides with an accept, `ri` ends at 1 (the set wins) and `fe`/`oe` end at 0.
- When it coincides with a `fe` or `oe` set, the set wins for that flag.
- Any other `ri_clr` clears all three flags.

**Aborts:** `ren` dropping in any non-IDLE state returns to IDLE on the next cycle, with no flag or output change. Flags are retained while `ren`=0.

**Runtime inputs:** changes to `mode9`/`sm2` mid-frame have no effect until the next start edge.

## Timing
- Let E be the start-edge detect cycle. Raw `rxd` fall to E is 2–3 cycles.
- Slot k starts at E+1+k·`CLK_PER_BIT`. Its decision falls at E+1+k·`CLK_PER_BIT`+H+1.
- Let S = `DATA_BITS`+1+`mode9` (the stop slot index). Frame results (`ri`, `fe`, `oe`, `data_out`, `rb8`) become visible at E+S·`CLK_PER_BIT`+H+3.
- Defaults with `mode9`=1: E+1053. With `mode9`=0: E+953.
- `busy` rises at E+1 and falls in the same cycle the results become visible.
- A false start: `busy` falls at E+H+3.
- Counter width is $clog2(`CLK_PER_BIT`). The bit index counts to at most `DATA_BITS`-1. No overflow is possible.

## Test plan
- Reset mid-frame (`rst_n` low at E+300) → all outputs 0 immediately; the next full frame is received correctly.
- `mode9`=1, `sm2`=0, send 0xA5 with 9th bit=1 and stop=1 → `data_out`=0xA5, `rb8`=1, `ri`=1 at E+1053. Then `ri_clr` → `ri`=0.
- `mode9`=1, `sm2`=1: send 0x3C with bit9=0 → no `ri`. Then send 0x7E with bit9=1 → `data_out`=0x7E, `ri`=1.
- Glitch: `rxd` low for 30 cycles only → false start, `busy` falls at E+53, no flags. Single-cycle low spike at the slot-3 midpoint of 0x00 → majority voting still yields 0x00.
- Overrun: accept 0x11, leave `ri`=1, then send 0x22 → `oe`=1, `data_out` stays 0x11. Same with `ri_clr` pulsed at the stop decision cycle → 0x22 accepted, `oe`=0.
- Framing: `mode9`=0, send 0x55 with stop=0 → `fe`=1, `ri`=0. Back-to-back 8-bit frames 0x01 then 0x02 with one stop bit → both accepted in order, with `ri_clr` applied between them.
